// File: rtl/cache_refill_ctrl.sv
// Miss engine for the 4-way/128-set/64B-line data cache: victim write-back, line fetch, one-cycle fill.
// Latency: 18 cycles miss-to-fill for a clean victim, 35 for a dirty one, plus any memory stall cycles.
// Backpressure: miss_ready only in IDLE; request/write outputs held until ready; read beats cannot be stalled.
module cache_refill_ctrl #(
  parameter int NUM_WAYS = 4,
  parameter int BEATS    = 16,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [31:0]           miss_addr,
  input  logic [31:0]           miss_pc,
  input  logic                  victim_dirty,
  input  logic [18:0]           victim_tag,
  input  logic [32*BEATS-1:0]   victim_line,
  output logic [WAY_W-1:0]      fill_way_hint,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [31:0]           mem_req_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  fill_valid,
  output logic [6:0]            fill_index,
  output logic [18:0]           fill_tag,
  output logic [WAY_W-1:0]      fill_way,
  output logic [32*BEATS-1:0]   fill_line,
  output logic [31:0]           fill_pc
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL} state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q;
  logic [WAY_W-1:0]      victim_q;
  logic [WAY_W-1:0]      way_q;
  logic [25:0]           line_addr_q;   // miss_addr[31:6]: tag in [25:7], index in [6:0]
  logic [31:0]           pc_q;
  logic [18:0]           vtag_q;
  logic [32*BEATS-1:0]   vline_q;       // shifts right one beat per accepted write beat
  logic [32*BEATS-33:0]  line_q;        // first BEATS-1 read beats; the last one goes straight to fill_line

  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[5:0];

  logic accept, wbeat, rbeat, last_rbeat;
  assign accept     = (state_q == IDLE) && miss_valid;
  assign wbeat      = (state_q == WB_DATA) && mem_wready;
  assign rbeat      = (state_q == RD_DATA) && mem_rvalid;
  assign last_rbeat = rbeat && (beat_q == LAST_BEAT);

  assign fill_way_hint = victim_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; everything idles at zero except miss_ready
  always_comb begin
    state_d       = state_q;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    fill_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        // The dirty flag is only needed for this one decision, made in the accept cycle
        if (miss_valid) state_d = victim_dirty ? WB_REQ : RD_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {vtag_q, line_addr_q[6:0], 6'b0};
        if (mem_req_ready) state_d = WB_DATA;
      end
      WB_DATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = vline_q[31:0];
        if (mem_wready && (beat_q == LAST_BEAT)) state_d = RD_REQ;
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {line_addr_q, 6'b0};
        if (mem_req_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (last_rbeat) state_d = FILL;
      end
      FILL: begin
        fill_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat counter shared by write-back and read; wraps to 0 on the last beat of each
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              beat_q <= '0;
    else if (wbeat || rbeat) beat_q <= beat_q + 1'b1;
  end

  // Round-robin victim way, advanced only when a fill completes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                victim_q <= '0;
    else if (state_q == FILL) victim_q <= (victim_q == LAST_WAY) ? '0 : victim_q + 1'b1;
  end

  // Capture the miss context at accept; victim data then drains one beat per write handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_addr_q <= '0;
      pc_q        <= '0;
      vtag_q      <= '0;
      way_q       <= '0;
      vline_q     <= '0;
    end else if (accept) begin
      line_addr_q <= miss_addr[31:6];
      pc_q        <= miss_pc;
      vtag_q      <= victim_tag;
      way_q       <= victim_q;
      vline_q     <= victim_line;
    end else if (wbeat) begin
      vline_q     <= {32'b0, vline_q[32*BEATS-1:32]};
    end
  end

  // Read assembly: beats enter at the top and shift down, so beat 0 ends in the low word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      line_q <= '0;
    else if (rbeat) line_q <= {mem_rdata, line_q[32*BEATS-33:32]};
  end

  // Fill outputs load with the last beat and hold until the next fill
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_index <= '0;
      fill_tag   <= '0;
      fill_way   <= '0;
      fill_line  <= '0;
      fill_pc    <= '0;
    end else if (last_rbeat) begin
      fill_index <= line_addr_q[6:0];
      fill_tag   <= line_addr_q[25:7];
      fill_way   <= way_q;
      fill_line  <= {mem_rdata, line_q};
      fill_pc    <= pc_q;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed misses against a small memory responder.
// Latency: measured from the cycle a miss is presented and accepted to the fill cycle.
// Backpressure: responder can stall requests, toggle wready and insert read gaps.
module tb_cache_refill_ctrl;

  typedef struct {
    logic [6:0]   idx;
    logic [18:0]  tag;
    logic [1:0]   way;
    logic [511:0] line;
    logic [31:0]  pc;
    int           lat;
  } fill_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
  } req_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic [31:0]  miss_pc;
  logic         victim_dirty;
  logic [18:0]  victim_tag;
  logic [511:0] victim_line;
  logic [1:0]   fill_way_hint;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b1;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_wdata;
  logic         mem_wvalid;
  logic         mem_wready = 1'b1;
  logic [31:0]  mem_rdata = 32'h0;
  logic         mem_rvalid = 1'b0;
  logic         fill_valid;
  logic [6:0]   fill_index;
  logic [18:0]  fill_tag;
  logic [1:0]   fill_way;
  logic [511:0] fill_line;
  logic [31:0]  fill_pc;

  cache_refill_ctrl dut (
    .clk(clk), .rstn(rstn),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr), .miss_pc(miss_pc),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line),
    .fill_way_hint(fill_way_hint),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag), .fill_way(fill_way),
    .fill_line(fill_line), .fill_pc(fill_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int fills_seen = 0;

  fill_t       exp_q[$];
  req_t        req_q[$];
  logic [31:0] wb_q[$];
  int          acc_q[$];
  logic [1:0]  hint_q[$];
  logic [1:0]  exp_way = 2'd0;

  // Responder knobs and state
  int          req_stall = 0;
  bit          wtoggle   = 1'b0;
  bit          gap_en    = 1'b0;
  logic [31:0] rd_base   = 32'h0;
  int          rd_left   = 0;
  int          rc        = 0;
  int          rd_sent   = 0;
  int          req_wait  = 0;
  int          wc        = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  // Memory responder: drives its inputs 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      rd_left = 0; req_wait = 0; wc = 0;
      mem_rvalid = 1'b0; mem_req_ready = 1'b1; mem_wready = 1'b1;
    end else begin
      if (rd_left > 0) begin
        if (gap_en && (rc % 3 == 1)) begin
          mem_rvalid = 1'b0;
        end else begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_base + 32'(16 - rd_left);
          rd_left--;
          rd_sent++;
        end
        rc++;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
      end
      if (mem_req_valid) begin
        mem_req_ready = (req_wait >= req_stall);
        req_wait++;
        if (mem_req_ready && !mem_req_write) begin
          rd_left = 16;
          rc      = 0;
        end
      end else begin
        mem_req_ready = (req_stall == 0);
        req_wait = 0;
      end
      if (mem_wvalid) begin
        mem_wready = !wtoggle || (wc % 2 == 0);
        wc++;
      end else begin
        mem_wready = 1'b1;
        wc = 0;
      end
    end
  end

  // Accept monitor: records the cycle and way hint of each accepted miss
  always @(negedge clk) begin
    if (rstn && miss_valid && miss_ready) begin
      acc_q.push_back(cyc);
      hint_q.push_back(fill_way_hint);
    end
  end

  // Fill monitor: pops the scoreboard whenever the DUT presents a fill
  always @(negedge clk) begin : mon_fill
    fill_t e;
    int a;
    logic [1:0] h;
    if (fill_valid) begin
      fills_seen++;
      if (exp_q.size() == 0) begin
        chk("fill_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        a = -1000;
        h = 2'bxx;
        if (acc_q.size() > 0) a = acc_q.pop_front();
        if (hint_q.size() > 0) h = hint_q.pop_front();
        chk("fill_index", fill_index, e.idx);
        chk("fill_tag", fill_tag, e.tag);
        chk("fill_way", fill_way, e.way);
        chk("fill_way_hint", h, e.way);
        chk("fill_line", fill_line, e.line);
        chk("fill_pc", fill_pc, e.pc);
        chk("fill_latency", 512'(cyc - a), 512'(e.lat));
      end
    end
  end

  // Memory request and write-beat monitor, plus stability while stalled
  logic [32:0] prev_req;
  logic [31:0] prev_w;
  bit          req_stalled = 1'b0;
  bit          w_stalled   = 1'b0;
  always @(negedge clk) begin : mon_mem
    req_t r;
    if (mem_req_valid && req_stalled) chk("req_stable", {mem_req_write, mem_req_addr}, prev_req);
    req_stalled = mem_req_valid && !mem_req_ready;
    prev_req    = {mem_req_write, mem_req_addr};
    if (mem_wvalid && w_stalled) chk("wdata_stable", mem_wdata, prev_w);
    w_stalled = mem_wvalid && !mem_wready;
    prev_w    = mem_wdata;
    if (mem_req_valid && mem_req_ready) begin
      if (req_q.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        r = req_q.pop_front();
        chk("req_write", mem_req_write, r.w);
        chk("req_addr", mem_req_addr, r.a);
      end
    end
    if (mem_wvalid && mem_wready) begin
      if (wb_q.size() == 0) chk("wbeat_unexpected", 1, 0);
      else chk("wbeat_data", mem_wdata, wb_q.pop_front());
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_miss_ready"}, miss_ready, 1);
    chk({tag, "_mem_outs"}, {mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata}, 0);
    chk({tag, "_fill_outs"}, {fill_valid, fill_index, fill_tag, fill_way, fill_pc}, 0);
    chk({tag, "_fill_line"}, fill_line, 0);
    chk({tag, "_way_hint"}, fill_way_hint, 0);
  endtask

  // Present one miss, queue its expectations, and return just after it is accepted
  task automatic issue(input logic [31:0] addr, input logic [31:0] pc, input bit dirty,
                       input logic [18:0] vtag, input logic [31:0] wb_addr, input logic [31:0] vbase,
                       input logic [31:0] rbase, input int lat,
                       input logic [6:0] x_idx, input logic [18:0] x_tag);
    fill_t e;
    req_t  r;
    int    n;
    @(posedge clk); #1;
    miss_valid   = 1'b1;
    miss_addr    = addr;
    miss_pc      = pc;
    victim_dirty = dirty;
    victim_tag   = vtag;
    victim_line  = mk_line(vbase);
    rd_base      = rbase;
    e.idx = x_idx; e.tag = x_tag; e.way = exp_way; e.line = mk_line(rbase); e.pc = pc; e.lat = lat;
    exp_q.push_back(e);
    exp_way = exp_way + 2'd1;
    if (dirty) begin
      r.w = 1'b1; r.a = wb_addr;
      req_q.push_back(r);
      for (int k = 0; k < 16; k++) wb_q.push_back(vbase + 32'(k));
    end
    r.w = 1'b0; r.a = {addr[31:6], 6'b0};
    req_q.push_back(r);
    n = 0;
    @(negedge clk);
    while (!miss_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("miss_accept", miss_ready, 1);
    @(posedge clk); #1;
    miss_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin : main
    int n;
    int sent0;
    int fills0;
    rstn = 1'b0;
    miss_valid = 1'b0; miss_addr = '0; miss_pc = '0;
    victim_dirty = 1'b0; victim_tag = '0; victim_line = '0;
    #12;
    chk_reset_outs("reset");
    @(negedge clk) rstn = 1'b1;

    // Clean miss, back-to-back beats 0..15
    issue(32'h0001_2340, 32'h1000_0000, 1'b0, 19'h0, 32'h0, 32'h0, 32'h0, 18, 7'h0D, 19'h00009);
    drain();

    // Dirty victim, tag 0x7FFFF at index 0x0D
    issue(32'h0004_A340, 32'h1000_0004, 1'b1, 19'h7FFFF, 32'hFFFF_E340, 32'hA000_0000,
          32'h0000_0100, 35, 7'h0D, 19'h00025);
    drain();

    // Back-pressure: 5+5 request stalls, 15 write stalls, 8 read gaps
    req_stall = 5; wtoggle = 1'b1; gap_en = 1'b1;
    issue(32'h0000_0080, 32'h2000_0000, 1'b1, 19'h12345, 32'h2468_A080, 32'hB000_0000,
          32'h0000_0200, 68, 7'h02, 19'h00000);
    drain();
    req_stall = 0; wtoggle = 1'b0; gap_en = 1'b0;

    // Reset while idle so the round-robin sequence starts from way 0
    @(negedge clk) rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
    exp_way = 2'd0;
    chk("idle_reset_hint", fill_way_hint, 0);

    // Five clean misses; the next miss is held pending while the current one is busy
    for (int i = 0; i < 5; i++) begin
      issue(32'h1000_0000 + 32'(i * 64), 32'h3000_0000 + 32'(i * 4), 1'b0, 19'h0, 32'h0, 32'h0,
            32'h0000_0300, 18, 7'(i), 19'h08000);
      if (i < 4) begin
        miss_valid = 1'b1;
        miss_addr  = 32'h1000_0000 + 32'((i + 1) * 64);
        miss_pc    = 32'h3000_0000 + 32'((i + 1) * 4);
        repeat (10) @(negedge clk);
        chk("busy_miss_ready", miss_ready, 0);
      end
    end
    drain();

    // Reset after read beat 7: no fill, outputs clear at once, victim counter back to 0
    sent0 = rd_sent;
    issue(32'h0000_1FC0, 32'h4000_0000, 1'b0, 19'h0, 32'h0, 32'h0, 32'h0000_0400, 18, 7'h7F, 19'h0);
    n = 0;
    while (rd_sent < sent0 + 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("beats_before_reset", 512'(rd_sent - sent0), 512'(8));
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk_reset_outs("midreset");
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    if (acc_q.size() > 0) void'(acc_q.pop_back());
    if (hint_q.size() > 0) void'(hint_q.pop_back());
    exp_way = 2'd0;
    fills0 = fills_seen;
    repeat (30) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_fill_after_reset", 512'(fills_seen), 512'(fills0));

    // First miss after reset reports way 0
    issue(32'h0001_2340, 32'h5000_0000, 1'b0, 19'h0, 32'h0, 32'h0, 32'h0000_0500, 18, 7'h0D, 19'h00009);
    drain();
    chk("req_q_empty", req_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
